// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size/sign codes,
// the unit's FSM state type, default memory geometry and a funct3 legality helper.
package lsu_pkg;

  localparam int MEM_WORDS_DEF = 7920;
  localparam int ADDR_W_DEF    = 14;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} lsu_state_t;

  // Stores only have signed-size encodings; loads add the unsigned B/H forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte/half lane logic for the load/store unit.
//  funct3_i  in  3   access size/sign
//  off_i     in  2   byte offset within the word (addr[1:0])
//  word_i    in  32  word read from memory
//  wdata_i   in  32  store data (low byte/half used for SB/SH)
//  load_o    out 32  extracted and sign/zero-extended load value
//  merge_o   out 32  word_i with the addressed byte/half replaced by wdata_i
// Offsets are assumed aligned for the size; misaligned requests never reach here.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_o = {24'h0, byte_sel};
      F3_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    case (funct3_i)
      F3_B:    merge_o[{off_i, 3'b000} +: 8]        = wdata_i[7:0];
      F3_H:    merge_o[{off_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte-addressed RV32I load/store requests and drives a
// word-addressed, async-read, sync-write data memory without byte enables
// (SB/SH are done as read-modify-write).
//  clock, reset_n             clock, synchronous active-low reset
//  req_valid/req_ready        request handshake (ready only when idle)
//  req_write/funct3/addr/wdata request fields, captured at accept
//  resp_valid/rdata/fault     one-cycle response pulse
//  mem_write_enable/address/write_data, mem_read_data   memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam logic [ADDR_W:0] WORD_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  lsu_state_t        state_q;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_fault_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [31:0]       mem_wdata_q;

  logic [ADDR_W-1:0] idx_d;
  logic              misalign_d;
  logic              fault_d;
  logic [31:0]       load_val;
  logic [31:0]       merge_val;

  // Fault decision on the live request; only used in the accept cycle.
  always_comb begin
    idx_d      = req_addr[ADDR_W+1:2];
    misalign_d = 1'b0;
    if (req_funct3[1:0] == 2'd1) misalign_d = req_addr[0];
    if (req_funct3[1:0] == 2'd2) misalign_d = |req_addr[1:0];
    fault_d = (|req_addr[31:ADDR_W+2]) || ({1'b0, idx_d} >= WORD_LIMIT) ||
              misalign_d || !f3_legal(req_write, req_funct3);
  end

  lsu_byte_lane u_lane (
    .funct3_i (funct3_q),
    .off_i    (off_q),
    .word_i   (mem_read_data),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .merge_o  (merge_val)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      wdata_q       <= 32'h0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      resp_fault_q  <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (fault_d) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              // Address is presented during ACCESS so the async read settles there.
              state_q       <= ACCESS;
              mem_address_q <= idx_d;
              if (req_write && req_funct3 == F3_W) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (write_q && funct3_q != F3_W) begin
            // Sub-word store: merged word is captured from the read and written next cycle.
            state_q     <= WRITE;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merge_val;
          end else begin
            state_q      <= DONE;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= write_q ? 32'h0 : load_val;
          end
        end
        WRITE: begin
          state_q      <= DONE;
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        DONE: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_fault       = resp_fault_q;
  // Reset kills a write in the same cycle, before the registered enable clears.
  assign mem_write_enable = mem_we_q & reset_n;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int MEM_WORDS = 7920;
  localparam int ADDR_W    = 14;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  logic [31:0] ram     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        ram_init;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;

  // Memory: async read, sync write.
  assign mem_read_data = (32'(mem_address) < MEM_WORDS) ? ram[mem_address] : 32'h0;

  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] <= 32'(i) * 32'h9E3779B9;
    end else if (mem_write_enable && 32'(mem_address) < MEM_WORDS) begin
      ram[mem_address] <= mem_write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what a request must do, from size/sign rules and plain arithmetic.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic flt, output logic [31:0] rd,
                       output int lat, output int nwr);
    int size;
    bit uns, legal;
    logic [31:0] word, val, mask;
    int sh;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    uns   = f3[2];
    legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    flt   = !legal || (a >= 32'(MEM_WORDS) * 4) || ((a % size) != 0);
    rd    = 32'h0;
    nwr   = 0;
    if (flt) begin
      lat = 1;
      return;
    end
    sh   = 8 * int'(a % 4);
    word = ref_mem[a / 4];
    mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? (32'hFFFF << sh) : (32'hFF << sh);
    if (w) begin
      ref_mem[a / 4] = (word & ~mask) | ((d << sh) & mask);
      nwr = 1;
      lat = (size == 4) ? 2 : 3;
    end else begin
      val = (word & mask) >> sh;
      if (!uns && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
      if (!uns && size == 2 && val[15]) val = val | 32'hFFFF_0000;
      rd  = val;
      lat = 2;
    end
  endtask

  // Issue one request at a negedge with the unit idle and check everything it produces.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic flt);
    logic        ef;
    logic [31:0] er;
    int          el, ew, lat, nwr;
    logic [31:0] wa;
    model(w, f3, a, d, ef, er, el, ew);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clock);
    lat = 0; nwr = 0; wa = 32'h0; rd = 32'h0; flt = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      req_valid = 1'b0;
      req_addr  = $urandom;
      if (mem_write_enable) begin nwr++; wa = 32'(mem_address); end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; flt = resp_fault;
        break;
      end
      chk("busy_not_ready", 32'(req_ready), 32'd0);
    end
    chk("latency", 32'(lat), 32'(el));
    chk("resp_fault", 32'(flt), 32'(ef));
    chk("resp_rdata", rd, er);
    chk("write_cycles", 32'(nwr), 32'(ew));
    if (ew == 1) chk("write_addr", wa, a / 4);
    if (!ef) chk("mem_word", ram[a / 4], ref_mem[a / 4]);
    @(negedge clock);
    chk("resp_pulse_end", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    logic [31:0] a, d;
    logic [2:0]  f3;
    logic        w;
    int          r;

    reset_n = 1'b0; ram_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'(i) * 32'h9E3779B9;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_fault", 32'(resp_fault), 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_wdata", mem_write_data, 32'h0);
    reset_n = 1'b1; ram_init = 1'b0;
    @(negedge clock);

    // SW then LW at 0x10
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, flt);
    chk("pin_sw_mem", ram[4], 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, flt);
    chk("pin_lw_rdata", rd, 32'hDEADBEEF);

    // SB/SH read-modify-write
    do_req(1'b1, 3'd2, 32'h10, 32'h11223344, rd, flt);
    do_req(1'b1, 3'd0, 32'h12, 32'h000000AA, rd, flt);
    chk("pin_sb_mem", ram[4], 32'h11AA3344);
    do_req(1'b1, 3'd1, 32'h10, 32'h0000BEEF, rd, flt);
    chk("pin_sh_mem", ram[4], 32'h11AABEEF);

    // Sign/zero extension
    do_req(1'b1, 3'd2, 32'h10, 32'h80FF7F01, rd, flt);
    do_req(1'b0, 3'd0, 32'h12, 32'h0, rd, flt);
    chk("pin_lb", rd, 32'hFFFFFFFF);
    do_req(1'b0, 3'd4, 32'h12, 32'h0, rd, flt);
    chk("pin_lbu", rd, 32'h000000FF);
    do_req(1'b0, 3'd1, 32'h12, 32'h0, rd, flt);
    chk("pin_lh", rd, 32'hFFFF80FF);
    do_req(1'b0, 3'd5, 32'h10, 32'h0, rd, flt);
    chk("pin_lhu", rd, 32'h00007F01);

    // Faults and boundaries
    do_req(1'b1, 3'd1, 32'h11, 32'h1234, rd, flt);
    chk("pin_sh_misalign", 32'(flt), 32'd1);
    do_req(1'b0, 3'd2, 32'h2, 32'h0, rd, flt);
    chk("pin_lw_misalign", 32'(flt), 32'd1);
    do_req(1'b1, 3'd2, 32'h7BC0, 32'hCAFEF00D, rd, flt);
    chk("pin_sw_oob", 32'(flt), 32'd1);
    do_req(1'b1, 3'd2, 32'h7BBC, 32'hCAFEF00D, rd, flt);
    chk("pin_sw_last", 32'(flt), 32'd0);
    chk("pin_sw_last_mem", ram[7919], 32'hCAFEF00D);
    do_req(1'b0, 3'd2, 32'h0, 32'h0, rd, flt);
    chk("pin_lw_addr0", 32'(flt), 32'd0);
    do_req(1'b1, 3'd3, 32'h20, 32'h5555, rd, flt);
    chk("pin_st_f3_3", 32'(flt), 32'd1);
    do_req(1'b0, 3'd6, 32'h20, 32'h0, rd, flt);
    chk("pin_ld_f3_6", 32'(flt), 32'd1);
    do_req(1'b0, 3'd2, 32'h0001_0000, 32'h0, rd, flt);
    chk("pin_high_addr", 32'(flt), 32'd1);

    // Reset during WRITE of an SB
    chk("rst6_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'h77;
    @(posedge clock);
    @(negedge clock); req_valid = 1'b0;
    @(negedge clock);
    chk("rst6_we_before", 32'(mem_write_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst6_we_gated", 32'(mem_write_enable), 32'd0);
    @(negedge clock);
    chk("rst6_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst6_ready_after", 32'(req_ready), 32'd1);
    chk("rst6_we_after", 32'(mem_write_enable), 32'd0);
    chk("rst6_addr", 32'(mem_address), 32'd0);
    chk("rst6_wdata", mem_write_data, 32'h0);
    chk("rst6_rdata", resp_rdata, 32'h0);
    chk("rst6_mem", ram[8], ref_mem[8]);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst6_no_late_resp", 32'(resp_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = $urandom_range(0, 127);
      else if (r < 8) a = 32'((MEM_WORDS - 2) * 4) + $urandom_range(0, 15);
      else if (r == 8) a = $urandom;
      else            a = $urandom_range(0, MEM_WORDS * 4 - 1);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        r  = $urandom_range(0, 4);
        f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      end
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      do_req(w, f3, a, d, rd, flt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
